add16_nibble_sched: RTL and testbench
=====================================

# add16_nibble_sched

Controller that shares one external 4-bit parallel adder between two requesters and sequences it over four cycles to perform 16-bit additions. Each requester presents two 16-bit operands and a carry-in through a valid/ready handshake. A round-robin arbiter grants one request at a time. The block then drives the adder one nibble per cycle, least significant nibble first, and chains the carry through an internal register. It returns the 16-bit sum, carry-out and requester ID on a valid/ready result port.

## Interface
Parameters:
- none; widths are fixed: 16-bit operands, 4-bit adder slice, 4 nibbles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a, req0_b  in  16  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1.
- add_a, add_b  out  4  nibble operands driven to the shared adder.
- add_cin  out  1  carry-in driven to the shared adder.
- add_sum  in  4  adder sum; combinational response to add_a, add_b, add_cin.
- add_cout  in  1  adder carry-out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  16  16-bit sum.
- res_cout  out  1  carry-out of nibble 3.
- res_id  out  1  requester that owns the result (0 or 1).

## Operation
State machine: IDLE, ADD, DONE.

IDLE:
- Arbitrate whenever either valid is high.
- Only one requester is valid: that requester is granted.
- Both are valid: the requester not in last_grant is granted.
- reqN_ready is combinational and high only for the granted requester, only in IDLE.
- On the handshake edge:
  - capture a, b and cin into operand registers;
  - record the requester in id_reg and update last_grant;
  - clear nib_idx to 0 and move to ADD.

ADD:
- add_a = a_reg[4*nib_idx+3 : 4*nib_idx]; add_b likewise.
- add_cin = cin_reg when nib_idx = 0; otherwise add_cin = carry_reg.
- Each edge:
  - add_sum is written into sum_reg[nibble];
  - add_cout is written into carry_reg;
  - nib_idx increments.
- After the nib_idx = 3 edge, move to DONE.
- Request valids are ignored in ADD.

DONE:
- res_valid = 1.
- res_sum = sum_reg, res_cout = carry_reg, res_id = id_reg; all three are held stable.
- When res_valid and res_ready are both high on an edge, move to IDLE.
- No request is accepted in DONE.

Outputs outside ADD:
- add_a, add_b and add_cin drive 0.
- res_sum, res_cout and res_id hold their last values; they are meaningful only while res_valid is high.

Arithmetic:
- res_cout:res_sum equals a + b + cin, as a 17-bit result.
- Wrap-around follows modulo 2^16 on res_sum, with the overflow bit in res_cout.

## Timing
Reset values (rst high, asynchronous):
- state = IDLE, nib_idx = 0.
- last_grant = 1, so requester 0 wins the first tie.
- res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0.
- carry_reg = 0, add_a = 0, add_b = 0, add_cin = 0.
- req0_ready = 0 and req1_ready = 0 while rst is high.

Latency and throughput:
- Request accepted at edge E0; nibble n is captured at edge E(n+1).
- res_valid rises after E4, i.e. 4 cycles after acceptance.
- With res_ready held high, the result handshake is at E5, IDLE follows, and the next accept is at E6.
- Maximum throughput is one addition per 6 cycles.

Boundary conditions:
- Simultaneous valids: exactly one ready is high; grants strictly alternate under continuous contention.
- A requester may drop valid before its handshake without any effect.
- res_ready held low: the block stays in DONE indefinitely with outputs stable, and both req_ready signals stay 0.
- Reset mid-ADD or mid-DONE: the operation is abandoned and everything returns to reset values immediately; no result is ever produced for it.

## Test plan
- Basic add: req0 with a=0x1234, b=0x4321, cin=0 -> res_sum=0x5555, res_cout=0, res_id=0; res_valid high exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> res_sum=0x0000, res_cout=1. Also a=0x000F, b=0x0000, cin=1 -> res_sum=0x0010, res_cout=0. Check add_cin equals the previous nibble's carry at each nibble.
- Arbitration: both requesters valid continuously -> first grant to req0, then req1, req0, req1. Check res_id sequence 0,1,0,1 and that only one ready is high per cycle.
- Backpressure: hold res_ready=0 for 10 cycles in DONE with req1_valid=1 -> res_sum, res_cout and res_id stay stable, req1_ready stays 0; req1 is accepted on the cycle after res_ready rises.
- Reset mid-operation: assert rst after nibble 1 -> res_valid=0 and all outputs at reset values immediately. A following req1 request (0x8000+0x8000) gives res_sum=0x0000, res_cout=1, res_id=1.
- Randomised regression: 1000 random operands and cin across both requesters, compared against a + b + cin in the scoreboard.

Source files
------------

// File: rtl/add16_nibble_sched.sv
// Two-requester 16-bit adder that time-shares one external 4-bit adder slice.
// It ripples one nibble per cycle (LSB first) and returns the result over a valid/ready port.
module add16_nibble_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_cin,
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_cin,
  input  logic [3:0]  add_sum,
  input  logic        add_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sum,
  output logic        res_cout,
  output logic        res_id
);

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned XW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   nib_q, nib_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;
  logic [DW-1:0]   res_sum_q, res_sum_d;
  logic            res_cout_q, res_cout_d;
  logic            res_id_q, res_id_d;

  logic            grant_id;
  logic            any_valid;
  logic [XW+1:0]   nib_base;

  // Round-robin: on contention the requester not served last time wins.
  assign any_valid = req0_valid | req1_valid;
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign nib_base  = {nib_q, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      nib_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      carry_q      <= 1'b0;
      sum_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      carry_q      <= carry_d;
      sum_q        <= sum_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_id_q     <= res_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    carry_d      = carry_q;
    sum_d        = sum_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_id_d     = res_id_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    add_a        = '0;
    add_b        = '0;
    add_cin      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid && !rst) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          a_d          = grant_id ? req1_a   : req0_a;
          b_d          = grant_id ? req1_b   : req0_b;
          cin_d        = grant_id ? req1_cin : req0_cin;
          id_d         = grant_id;
          last_grant_d = grant_id;
          nib_d        = '0;
          state_d      = S_ADD;
        end
      end

      S_ADD: begin
        // Nibble 0 takes the requester's carry-in, later nibbles the chained carry.
        add_a   = a_q[nib_base +: NW];
        add_b   = b_q[nib_base +: NW];
        add_cin = (nib_q == XW'(0)) ? cin_q : carry_q;
        sum_d[nib_base +: NW] = add_sum;
        carry_d = add_cout;
        nib_d   = nib_q + XW'(1);
        if (nib_q == XW'(3)) begin
          res_sum_d  = sum_d;
          res_cout_d = add_cout;
          res_id_d   = id_q;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign res_valid = (state_q == S_DONE);
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_add16_nibble_sched.sv
// Directed and random checks for add16_nibble_sched against a behavioural 4-bit adder slice.
module tb_add16_nibble_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_ready, res_cout, res_id;
  logic [15:0] res_sum;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // External shared adder slice.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  add16_nibble_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
  );

  typedef struct {
    bit          id;
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    logic [15:0] es;
    bit          ec;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input bit id, input bit v, input logic [15:0] a, input logic [15:0] b, input bit cin);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  // Starts and ends at a negedge. Checks per-nibble drive, latency and result.
  task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b, input bit cin,
                        input logic [15:0] es, input bit ec, input string name);
    int   k;
    logic carry;
    logic [4:0] ns;
    bit   lat_ok;
    set_req(id, 1'b1, a, b, cin);
    #1;
    k = 0;
    while (!rdy(id) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rdy(id)) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      set_req(id, 1'b0, a, b, cin);
      @(negedge clk);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    set_req(id, 1'b0, a, b, cin);
    carry  = cin;
    lat_ok = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s_add_a%0d", name, n), add_a, a[4*n +: 4]);
      chk($sformatf("%s_add_cin%0d", name, n), add_cin, carry);
      ns    = 5'(a[4*n +: 4]) + 5'(b[4*n +: 4]) + 5'(carry);
      carry = ns[4];
      if (res_valid) lat_ok = 1'b0;
      @(negedge clk);
    end
    chk({name, "_latency4"}, {31'd0, lat_ok & res_valid}, 32'd1);
    chk({name, "_sum"},  res_sum,  es);
    chk({name, "_cout"}, res_cout, ec);
    chk({name, "_id"},   res_id,   id);
    if (res_ready) begin
      @(negedge clk);
      chk({name, "_res_released"}, res_valid, 1'b0);
    end
  endtask

  initial begin
    int          got, onehot_bad, bad;
    bit          ids [4];
    logic [15:0] sums [4];
    bit          rid, rcin;
    logic [15:0] ra, rb;
    logic [16:0] full;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0};
    vecs[7] = '{1'b1, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};

    // Reset state with both valids raised.
    rst = 1'b1;
    res_ready = 1'b1;
    set_req(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    set_req(1'b1, 1'b1, 16'h0100, 16'h0F00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_res_valid",  res_valid,  1'b0);
    chk("rst_res_sum",    res_sum,    16'h0000);
    chk("rst_res_cout",   res_cout,   1'b0);
    chk("rst_res_id",     res_id,     1'b0);
    chk("rst_add_a",      add_a,      4'h0);
    chk("rst_add_cin",    add_cin,    1'b0);
    rst = 1'b0;

    // Continuous contention straight out of reset: grants 0,1,0,1.
    got = 0;
    onehot_bad = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) onehot_bad++;
      if (res_valid) begin
        ids[got]  = res_id;
        sums[got] = res_sum;
        got++;
      end
    end
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("arb_count", got, 4);
    chk("arb_onehot", onehot_bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("arb_id%0d", i), ids[i], i % 2);
      chk($sformatf("arb_sum%0d", i), sums[i], (i % 2) ? 16'h1000 : 16'h3333);
    end
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].es, vecs[i].ec, $sformatf("vec%0d", i));

    // Backpressure: result held, pending req1 blocked.
    res_ready = 1'b0;
    run_op(1'b0, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, "bp");
    set_req(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (res_sum !== 16'h1235 || res_cout !== 1'b0 || res_id !== 1'b0 ||
          req1_ready !== 1'b0 || req0_ready !== 1'b0 || res_valid !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("bp_stable", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_req1_ready_after", req1_ready, 1'b1);
    run_op(1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "bp_req1");

    // Reset after nibble 1 of an operation.
    set_req(1'b0, 1'b1, 16'h5555, 16'h5555, 1'b1);
    #1;
    for (int k = 0; k < 20 && !req0_ready; k++) @(negedge clk);
    chk("mid_accept", req0_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    #1;
    chk("mid_rst_res_valid", res_valid,  1'b0);
    chk("mid_rst_res_sum",   res_sum,    16'h0000);
    chk("mid_rst_res_cout",  res_cout,   1'b0);
    chk("mid_rst_res_id",    res_id,     1'b0);
    chk("mid_rst_add_a",     add_a,      4'h0);
    chk("mid_rst_add_b",     add_b,      4'h0);
    chk("mid_rst_add_cin",   add_cin,    1'b0);
    chk("mid_rst_req1_rdy",  req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "post_rst");

    // Random regression against a 17-bit reference sum.
    for (int i = 0; i < 1000; i++) begin
      rid  = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      full = 17'(ra) + 17'(rb) + 17'(rcin);
      run_op(rid, ra, rb, rcin, full[15:0], full[16], $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
